// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow wave scheduler.
package arrow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_SPAWN = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_TOP    = 2'b00;
  localparam logic [1:0] DIR_BOTTOM = 2'b01;
  localparam logic [1:0] DIR_WEST   = 2'b10;
  localparam logic [1:0] DIR_EAST   = 2'b11;

  localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right.
// The state loads the seed on reset and steps only when enabled.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic fb;

  assign fb = state[0] ^ state[2] ^ state[3] ^ state[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= {fb, state[15:1]};
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Spawns a wave of arrows into a fixed pool of slots, one spawn per gap of
// frames, ramping speed as the wave progresses and tracking the oldest arrow.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int          NUM_SLOTS  = 4,
  parameter int          WAVE_LEN   = 32,
  parameter int          GAP_FRAMES = 30,
  parameter int          BASE_SPEED = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic [NUM_SLOTS-1:0]   slot_done,
  output logic [NUM_SLOTS-1:0]   valid_out,
  output logic [2*NUM_SLOTS-1:0] direction_out,
  output logic [3*NUM_SLOTS-1:0] speed_out,
  output logic [NUM_SLOTS-1:0]   inversed_out,
  output logic [NUM_SLOTS-1:0]   next_out,
  output logic [7:0]             arrows_left,
  output logic                   busy,
  output logic                   wave_done,
  output state_t                 state_dbg
);

  localparam int          SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0]  GAP_INIT   = 8'(GAP_FRAMES);
  localparam logic [7:0]  WAVE_INIT  = 8'(WAVE_LEN);
  localparam logic [2:0]  SPEED_INIT = 3'(BASE_SPEED);

  // Slot handshake: valid_out[i] rises for a newly allocated arrow and holds,
  // with its parameters frozen, until the arrow answers with slot_done[i]; the
  // slot then stays low for at least one cycle before it can be reused.
  state_t               state, state_nxt;
  logic [7:0]           gap_cnt;
  logic [7:0]           seq_cnt;
  logic [7:0]           seq_tag [NUM_SLOTS];
  logic [2:0]           speed;
  logic [2:0]           spawn_mod;
  logic [15:0]          lfsr_q;
  logic                 frame_tick;
  logic                 any_free;
  logic                 spawn_en;
  logic [SLOT_W-1:0]    alloc_idx;
  logic [NUM_SLOTS-1:0] next_d;
  logic [1:0]           new_dir;
  logic                 new_inv;
  logic                 unused_lfsr;

  assign frame_tick  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign any_free    = ~&valid_out;
  assign new_dir     = lfsr_q[1:0];
  assign new_inv     = (speed >= 3'd4) ? (lfsr_q[2] & lfsr_q[3]) : 1'b0;
  assign unused_lfsr = ^lfsr_q[15:4];
  assign state_dbg   = state;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (spawn_en),
    .seed  (LFSR_SEED),
    .state (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == 8'd0 && any_free) state_nxt = ST_SPAWN;
      ST_SPAWN: state_nxt = (arrows_left == 8'd1) ? ST_DRAIN : ST_GAP;
      ST_DRAIN: if (valid_out == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    spawn_en  = (state == ST_SPAWN);
    busy      = (state != ST_IDLE);
    wave_done = (state == ST_DONE);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_out[i]) alloc_idx = SLOT_W'(i);
    end
  end

  // Age is measured from the running sequence counter so tags may wrap.
  always_comb begin
    logic [7:0] best_age;
    logic       found;
    next_d   = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_out[i] && (!found || (seq_cnt - seq_tag[i]) > best_age)) begin
        next_d    = '0;
        next_d[i] = 1'b1;
        best_age  = seq_cnt - seq_tag[i];
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt     <= '0;
      arrows_left <= '0;
      speed       <= SPEED_INIT;
      spawn_mod   <= '0;
      seq_cnt     <= '0;
    end else if (state == ST_IDLE && start) begin
      gap_cnt     <= GAP_INIT;
      arrows_left <= WAVE_INIT;
      speed       <= SPEED_INIT;
      spawn_mod   <= '0;
    end else if (state == ST_GAP && frame_tick && gap_cnt != 8'd0) begin
      gap_cnt <= gap_cnt - 8'd1;
    end else if (spawn_en) begin
      gap_cnt     <= GAP_INIT;
      arrows_left <= arrows_left - 8'd1;
      seq_cnt     <= seq_cnt + 8'd1;
      spawn_mod   <= spawn_mod + 3'd1;
      if (spawn_mod == 3'd7 && speed != SPEED_MAX) speed <= speed + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= '0;
      direction_out <= '0;
      speed_out     <= '0;
      inversed_out  <= '0;
      next_out      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) seq_tag[i] <= '0;
    end else begin
      next_out <= next_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (spawn_en && alloc_idx == SLOT_W'(i)) begin
          valid_out[i]          <= 1'b1;
          direction_out[2*i +: 2] <= new_dir;
          speed_out[3*i +: 3]   <= speed;
          inversed_out[i]       <= new_inv;
          seq_tag[i]            <= seq_cnt;
        end else if (slot_done[i]) begin
          valid_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Bench for arrow_scheduler: directed waves checked every cycle against a
// queue-based wave model, plus hand-computed literal expectations.
module tb_arrow_scheduler;
  import arrow_pkg::*;

  localparam int          NS   = 4;
  localparam int          WL   = 32;
  localparam int          GF   = 2;
  localparam int          BS   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [NS-1:0] slot_done;
  logic [NS-1:0] valid_out;
  logic [2*NS-1:0] direction_out;
  logic [3*NS-1:0] speed_out;
  logic [NS-1:0] inversed_out;
  logic [NS-1:0] next_out;
  logic [7:0]    arrows_left;
  logic          busy;
  logic          wave_done;
  state_t        state_dbg;

  always #5 clk = ~clk;

  arrow_scheduler #(
    .NUM_SLOTS(NS), .WAVE_LEN(WL), .GAP_FRAMES(GF), .BASE_SPEED(BS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hcount_in(hcount), .vcount_in(vcount),
    .slot_done(slot_done), .valid_out(valid_out), .direction_out(direction_out),
    .speed_out(speed_out), .inversed_out(inversed_out), .next_out(next_out),
    .arrows_left(arrows_left), .busy(busy), .wave_done(wave_done), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- wave model ----------------
  // phase: 0 idle, 1 waiting out the gap, 2 spawning, 3 draining, 4 done
  int            m_phase;
  int            m_gap, m_left, m_idx;
  bit [NS-1:0]   m_valid, m_next;
  bit [1:0]      m_dir [NS];
  bit [2:0]      m_spd [NS];
  bit            m_inv [NS];
  bit [15:0]     m_lfsr;
  int            m_order[$];
  bit            chk_en = 1'b0;

  // Feedback polynomial x^16+x^14+x^13+x^11+1 seen from the shift-out end.
  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    bit [15:0] tapmask;
    tapmask = 16'h002D;
    return {^(s & tapmask), s[15:1]};
  endfunction

  always @(posedge clk) begin
    bit [NS-1:0] freed, nn;
    int s, sp;
    nn = '0;
    if (m_order.size() > 0) nn[m_order[0]] = 1'b1;
    if (rst) begin
      m_phase = 0; m_gap = 0; m_left = 0; m_idx = 0;
      m_valid = '0; m_next = '0; m_lfsr = SEED;
      m_order.delete();
      for (int i = 0; i < NS; i++) begin
        m_dir[i] = '0; m_spd[i] = '0; m_inv[i] = 1'b0;
      end
    end else begin
      freed = slot_done & m_valid;
      case (m_phase)
        0: if (start) begin
          m_gap = GF; m_left = WL; m_idx = 0; m_phase = 1;
        end
        1: begin
          if (m_gap == 0 && !(&m_valid)) m_phase = 2;
          else if (hcount == 0 && vcount == 0 && m_gap > 0) m_gap--;
        end
        2: begin
          s = 0;
          while (s < NS - 1 && m_valid[s]) s++;
          sp = BS + m_idx / 8;
          if (sp > 7) sp = 7;
          m_dir[s] = m_lfsr[1:0];
          m_spd[s] = 3'(sp);
          m_inv[s] = (sp >= 4) && m_lfsr[2] && m_lfsr[3];
          m_lfsr = lfsr_next(m_lfsr);
          m_left--; m_idx++;
          m_valid[s] = 1'b1;
          m_order.push_back(s);
          m_gap = GF;
          m_phase = (m_left == 0) ? 3 : 1;
        end
        3: if (m_valid == '0) m_phase = 4;
        default: m_phase = 0;
      endcase
      m_valid &= ~freed;
      for (int k = m_order.size() - 1; k >= 0; k--) begin
        if (freed[m_order[k]]) m_order.delete(k);
      end
      m_next = nn;
    end
  end

  always @(negedge clk) begin
    logic [2*NS-1:0] ed;
    logic [3*NS-1:0] es;
    logic [NS-1:0]   ei;
    if (chk_en) begin
      for (int i = 0; i < NS; i++) begin
        ed[2*i +: 2] = m_dir[i];
        es[3*i +: 3] = m_spd[i];
        ei[i]        = m_inv[i];
      end
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("next_out", 32'(next_out), 32'(m_next));
      chk("direction_out", 32'(direction_out), 32'(ed));
      chk("speed_out", 32'(speed_out), 32'(es));
      chk("inversed_out", 32'(inversed_out), 32'(ei));
      chk("arrows_left", 32'(arrows_left), 32'(m_left));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("wave_done", 32'(wave_done), 32'(m_phase == 4));
    end
  end

  // Speed each arrow was launched with, in launch order, for the first wave.
  logic [2:0]    spd_seen[$];
  logic [NS-1:0] prev_valid = '0;
  bit            cap_en = 1'b0;

  always @(negedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < NS; i++) begin
        if (valid_out[i] && !prev_valid[i]) spd_seen.push_back(speed_out[3*i +: 3]);
      end
    end
    prev_valid = valid_out;
  end

  // ---------------- drivers ----------------
  task automatic step(input bit tick, input logic [NS-1:0] sd, input bit st);
    @(negedge clk);
    hcount    = tick ? 11'd0 : 11'd7;
    vcount    = tick ? 10'd0 : 10'd3;
    slot_done = sd;
    start     = st;
  endtask

  task automatic fill_until(input logic [NS-1:0] target, input string name);
    int n;
    n = 0;
    while (valid_out !== target && n < 300) begin
      step(n % 3 == 0, '0, 1'b0);
      n++;
    end
    chk(name, 32'(valid_out), 32'(target));
  endtask

  initial begin
    int n, wd_count;
    rst = 1'b1; start = 1'b0; hcount = 11'd7; vcount = 10'd3; slot_done = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset valid_out", 32'(valid_out), 32'h0);
    chk("reset arrows_left", 32'(arrows_left), 32'h0);
    chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;

    // Wave 1: fill all four slots, then spawning stalls.
    cap_en = 1'b1;
    step(0, '0, 1'b1);
    fill_until(4'hF, "fill four slots");
    for (int i = 0; i < 9; i++) step(i % 3 == 0, '0, 1'b0);
    chk("stall arrows_left", 32'(arrows_left), 32'd28);
    chk("stall valid_out", 32'(valid_out), 32'hF);
    chk("stall next_out", 32'(next_out), 32'h1);
    chk("first four directions", 32'(direction_out), 32'h01);
    chk("first four speeds", 32'(speed_out), 32'h492);
    chk("first four inversed", 32'(inversed_out), 32'h0);

    // Free slot 0 while full: low one cycle, then reused as the newest arrow.
    step(0, 4'b0001, 1'b0);
    step(0, '0, 1'b0);
    chk("slot0 freed", 32'(valid_out), 32'hE);
    repeat (4) step(0, '0, 1'b0);
    chk("slot0 reused", 32'(valid_out), 32'hF);
    chk("next after slot0 reuse", 32'(next_out), 32'h2);

    // Two slots freed together.
    step(0, 4'b0110, 1'b0);
    step(0, '0, 1'b0);
    chk("slots 1,2 freed", 32'(valid_out), 32'h9);
    repeat (3) step(0, '0, 1'b0);
    chk("next after 1,2 freed", 32'(next_out), 32'h8);

    // Rest of the wave with prompt frees; a start pulse mid-wave is ignored.
    step(0, '0, 1'b1);
    wd_count = 0;
    n = 0;
    while (!(wd_count > 0 && !busy) && n < 4000) begin
      step(n % 3 == 0, (n % 5 == 0) ? valid_out : 4'b0000, 1'b0);
      if (wave_done) wd_count++;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1'b0);
      if (wave_done) wd_count++;
    end
    cap_en = 1'b0;
    chk("wave_done pulses", 32'(wd_count), 32'd1);
    chk("idle after wave", 32'(busy), 32'd0);
    chk("spawns seen", 32'(spd_seen.size()), 32'd32);
    if (spd_seen.size() == 32) begin
      chk("speed spawn 1", 32'(spd_seen[0]), 32'd2);
      chk("speed spawn 8", 32'(spd_seen[7]), 32'd2);
      chk("speed spawn 9", 32'(spd_seen[8]), 32'd3);
      chk("speed spawn 17", 32'(spd_seen[16]), 32'd4);
      chk("speed spawn 25", 32'(spd_seen[24]), 32'd5);
      chk("speed spawn 32", 32'(spd_seen[31]), 32'd5);
    end

    // Wave 2: reset in GAP with three arrows up, then restart.
    step(0, '0, 1'b1);
    fill_until(4'h7, "three slots before reset");
    chk("in gap before reset", 32'(state_dbg), 32'(ST_GAP));
    rst = 1'b1;
    step(0, '0, 1'b0);
    rst = 1'b0;
    chk("reset drops valid", 32'(valid_out), 32'h0);
    chk("reset drops busy", 32'(busy), 32'd0);
    chk("reset no wave_done", 32'(wave_done), 32'd0);
    step(0, '0, 1'b1);
    fill_until(4'hF, "refill after reset");
    chk("directions repeat after reset", 32'(direction_out), 32'h01);
    repeat (3) step(0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arrow_scheduler.md
ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, 4, number of arrow instances driven (one slot each).
REQ-002 Parameter WAVE_LEN, 32, arrows spawned per wave.
REQ-003 Parameter GAP_FRAMES, 30, frames between consecutive spawns.
REQ-004 Parameter BASE_SPEED, 2, initial speed (3-bit).
REQ-005 Parameter LFSR_SEED, 16'hACE1, non-zero LFSR reset value.
REQ-006 clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse, begins a wave.
REQ-009 hcount_in  in  11  pixel column; vcount_in  in  10  pixel row.
REQ-010 slot_done  in  NUM_SLOTS  per-slot is_hit pulse from arrow instances.
REQ-011 valid_out  out  NUM_SLOTS  per-slot arrow enable (valid_in of arrow).
REQ-012 direction_out  out  2 x NUM_SLOTS; speed_out  out  3 x NUM_SLOTS; inversed_out  out  NUM_SLOTS; next_out  out  NUM_SLOTS.
REQ-013 arrows_left  out  8  arrows not yet spawned this wave; busy  out  1  state != IDLE; wave_done  out  1  one-cycle pulse.

Function
REQ-014 Frame tick SHALL be the single cycle where hcount_in==0 and vcount_in==0.
REQ-015 FSM states SHALL be IDLE, GAP, SPAWN, DRAIN, DONE.
REQ-016 IDLE: on start, load gap counter with GAP_FRAMES, arrows_left with WAVE_LEN, speed with BASE_SPEED, go GAP; start in any other state is ignored.
REQ-017 GAP: decrement gap counter on each frame tick, saturating at 0; when counter==0 and at least one slot free, go SPAWN; otherwise hold.
REQ-018 SPAWN (one cycle): allocate lowest-index free slot; set its direction from LFSR[1:0], inversed from LFSR[2]&LFSR[3] only when speed>=4 else 0, speed from current speed; assert its valid_out; advance LFSR once; decrement arrows_left; stamp slot with 8-bit spawn sequence number.
REQ-019 After SPAWN: if arrows_left reaches 0 go DRAIN, else reload gap counter and go GAP.
REQ-020 Speed SHALL increment by 1 after every 8th spawn, saturating at 7.
REQ-021 Slot parameters (direction, speed, inversed) SHALL stay constant while its valid_out is high.
REQ-022 slot_done[i] with valid_out[i] high SHALL clear valid_out[i] next cycle; slot_done on an idle slot ignored.
REQ-023 A freed slot SHALL NOT be reallocated in the same cycle it is freed, guaranteeing valid_out low for at least one cycle (arrow rising-edge detect).
REQ-024 Multiple simultaneous slot_done bits SHALL all be honoured in one cycle; slot_done coincident with SPAWN does not affect the slot being allocated.
REQ-025 next_out SHALL be one-hot on the active slot with the smallest sequence number, all zero when no slot active; registered, one cycle after allocation/free.
REQ-026 DRAIN: when all valid_out low go DONE; DONE asserts wave_done one cycle and returns to IDLE.
REQ-027 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances only in SPAWN.

Reset
REQ-028 rst SHALL force IDLE, all valid_out/next_out/inversed_out 0, direction_out/speed_out 0, arrows_left 0, wave_done 0, LFSR to LFSR_SEED, sequence counter 0.
REQ-029 rst mid-wave SHALL drop all valid_out in the following cycle with no wave_done pulse.

Structure
REQ-030 Package arrow_pkg SHALL hold direction encoding (DIR_TOP=2'b00, DIR_BOTTOM=2'b01, DIR_WEST=2'b10, DIR_EAST=2'b11), FSM state typedef, SPEED_MAX=7.
REQ-031 One sub-module lfsr16 (enable, seed, 16-bit state) SHALL be instantiated.

Verification
REQ-032 start, GAP_FRAMES=2, no slot_done -> first valid_out[0] rises after 2nd frame tick; slots 0..3 fill, then spawning stalls with arrows_left=WAVE_LEN-4.
REQ-033 slot_done[0] pulse while all full -> valid_out[0] low >=1 cycle, then reallocated to slot 0; next_out moves from 0001 to 0010.
REQ-034 slot_done[1] and slot_done[2] same cycle -> both cleared next cycle; next_out unaffected if slot 0 older.
REQ-035 Full WAVE_LEN=32 run with prompt slot_done -> speed 2,3,4,5,6 after spawns 8,16,24,32-capped; inversed_out 0 while speed<4; single wave_done pulse after last free.
REQ-036 rst asserted in GAP with 3 slots active -> next cycle valid_out=0, busy=0, no wave_done; restart reproduces identical LFSR direction sequence.
